sel9_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the shared 24-bit 9-way output selector.
//  Up to 8 requesters compete for the selector. The block drives its active-low one-hot

---
 rtl/sel9_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_sel9_rr_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sel9_rr_arbiter.sv
// Round-robin arbiter for the 24-bit 9-way output selector (8 requesters + default).
// Optional grant-extension lock enabled by defining SEL9_ARB_LOCK_EN.
`timescale 1ns/1ps
module sel9_rr_arbiter #(
  parameter int NREQ    = 8,
  parameter int QUANTUM = 16,
  parameter int QW      = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            lock,
  output logic [7:0]      sel,
  output logic            EN,
  output logic            grant_valid,
  output logic [2:0]      grant_id
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_SWITCH = 2'd2;

  localparam logic [QW-1:0] DW_Q   = QW'(QUANTUM);
  localparam logic [QW-1:0] DW_ONE = QW'(1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [QW-1:0] dwell_q, dwell_d;
  logic [7:0]    sel_q, sel_d;
  logic          en_q, en_d;
  logic          gv_q, gv_d;
  logic [2:0]    gid_q, gid_d;

  logic          found;
  logic [2:0]    pick;
  logic [2:0]    idx;
  logic [7:0]    own_mask;
  logic          own;
  logic          others;
  logic          at_q;
  logic          hold;

  // Scan ptr+8 first so ptr+1 wins last, i.e. has highest priority.
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    idx   = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      idx = ptr_q + 3'(i);
      if (req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign own_mask = 8'b1 << gid_q;
  assign own      = |(req & own_mask);
  assign others   = |(req & ~own_mask);
  assign at_q     = (dwell_q == DW_Q);

`ifdef SEL9_ARB_LOCK_EN
  assign hold = lock & own;
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    sel_d   = sel_q;
    en_d    = en_q;
    gid_d   = gid_q;
    case (state_q)
      S_IDLE, S_SWITCH: begin
        if (found) begin
          state_d = S_GRANT;
          sel_d   = ~(8'b1 << pick);
          en_d    = 1'b1;
          gid_d   = pick;
          ptr_d   = pick;
          dwell_d = DW_ONE;
        end else begin
          state_d = S_IDLE;
          sel_d   = 8'hFF;
          en_d    = 1'b0;
          dwell_d = '0;
        end
      end
      S_GRANT: begin
        if (!own || (at_q && !hold && others)) begin
          // Dead cycle so two select lines are never low together.
          state_d = S_SWITCH;
          sel_d   = 8'hFF;
          en_d    = 1'b0;
          dwell_d = '0;
        end else if (at_q && hold) begin
          dwell_d = DW_Q;
        end else if (at_q) begin
          dwell_d = DW_ONE;
        end else begin
          dwell_d = dwell_q + DW_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = 8'hFF;
        en_d    = 1'b0;
        dwell_d = '0;
      end
    endcase
    gv_d = en_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd7;
      dwell_q <= '0;
      sel_q   <= 8'hFF;
      en_q    <= 1'b0;
      gv_q    <= 1'b0;
      gid_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      gv_q    <= gv_d;
      gid_q   <= gid_d;
    end
  end

  assign sel         = sel_q;
  assign EN          = en_q;
  assign grant_valid = gv_q;
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_sel9_rr_arbiter.sv
// Scoreboard bench for sel9_rr_arbiter: directed vectors, monitor pops expectations.
`timescale 1ns/1ps
module tb_sel9_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       lock;
  logic [7:0] sel;
  logic       EN;
  logic       grant_valid;
  logic [2:0] grant_id;

  always #5 clk = ~clk;

  sel9_rr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .lock       (lock),
    .sel        (sel),
    .EN         (EN),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  typedef struct {
    logic [7:0] sel;
    logic       en;
    logic [2:0] gid;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic lk,
                      input logic [7:0] es, input logic ee,
                      input logic [2:0] eg, input string tag);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    lock = lk;
    e.sel = es;
    e.en  = ee;
    e.gid = eg;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: every post-edge sample consumes one expectation.
  always @(posedge clk) begin
    exp_t e;
    logic [7:0] z;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_sel"}, 32'(sel), 32'(e.sel));
      chk({e.tag, "_en"}, 32'(EN), 32'(e.en));
      chk({e.tag, "_gid"}, 32'(grant_id), 32'(e.gid));
      chk({e.tag, "_gv"}, 32'(grant_valid), 32'(e.en));
      z = ~sel;
      chk({e.tag, "_onehot"}, 32'($onehot0(z)), 32'd1);
    end
  end

  initial begin
    logic [7:0] one;
    logic [7:0] s;
    int         wait_cyc;
    one  = 8'b1;
    rst  = 1'b1;
    req  = 8'h00;
    lock = 1'b0;

    step(1, 8'h00, 0, 8'hFF, 0, 3'd0, "t1_rst");
    repeat (5) step(0, 8'h00, 0, 8'hFF, 0, 3'd0, "t1_idle");

    step(0, 8'h04, 0, 8'hFB, 1, 3'd2, "t2_first");
    repeat (40) step(0, 8'h04, 0, 8'hFB, 1, 3'd2, "t2_renew");
    step(1, 8'h00, 0, 8'hFF, 0, 3'd0, "t2_rst");

    for (int g = 0; g < 8; g++) begin
      s = ~(one << g);
      repeat (16) step(0, 8'hFF, 0, s, 1, 3'(g), "t3_grant");
      step(0, 8'hFF, 0, 8'hFF, 0, 3'(g), "t3_gap");
    end
    step(0, 8'hFF, 0, 8'hFE, 1, 3'd0, "t3_wrap");
    step(1, 8'h00, 0, 8'hFF, 0, 3'd0, "t3_rst");

    step(0, 8'h08, 0, 8'hF7, 1, 3'd3, "t4_g3");
    repeat (4) step(0, 8'h08, 0, 8'hF7, 1, 3'd3, "t4_dwell");
    step(0, 8'h40, 0, 8'hFF, 0, 3'd3, "t4_switch");
    step(0, 8'h40, 0, 8'hBF, 1, 3'd6, "t4_g6");
    step(0, 8'h00, 0, 8'hFF, 0, 3'd6, "t4_drop");
    step(0, 8'h00, 0, 8'hFF, 0, 3'd6, "t4_idle");

    step(0, 8'h20, 0, 8'hDF, 1, 3'd5, "t5_g5");
    step(0, 8'h20, 0, 8'hDF, 1, 3'd5, "t5_hold");
    step(1, 8'hFF, 0, 8'hFF, 0, 3'd0, "t5_rst");
    step(0, 8'hFF, 0, 8'hFE, 1, 3'd0, "t5_first");
    step(1, 8'h00, 0, 8'hFF, 0, 3'd0, "t5_rst2");

    step(0, 8'h02, 0, 8'hFD, 1, 3'd1, "t6_g1");
    repeat (15) step(0, 8'h03, 1, 8'hFD, 1, 3'd1, "t6_dwell");
`ifdef SEL9_ARB_LOCK_EN
    repeat (40) step(0, 8'h03, 1, 8'hFD, 1, 3'd1, "t6_locked");
    step(0, 8'h03, 0, 8'hFF, 0, 3'd1, "t6_unlock");
`else
    step(0, 8'h03, 1, 8'hFF, 0, 3'd1, "t6_nolock");
`endif
    step(0, 8'h03, 0, 8'hFE, 1, 3'd0, "t6_g0");

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
